// File: rtl/inst_mem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them
// to instruction memory addresses 0..count-1 while holding the CPU stalled.
module inst_mem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Byte handshake: a byte moves on a rising edge where in_valid && in_ready;
  // the source holds in_data stable until then, and in_ready never waits on in_valid.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              count_legal;

  assign count_legal = (word_count != '0) && (word_count <= DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_legal) begin
            count_d    = word_count;
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        // Abort wins over a byte arriving in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (in_valid) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ({1'b0, addr_q} == (count_q - CNT_ONE)) begin
          state_d = S_DONE;
        end else begin
          addr_d     = addr_q + ADDR_ONE;
          byte_cnt_d = '0;
          state_d    = S_RECV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_RECV);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = (state_q == S_WRITE) ? addr_q : '0;
  assign mem_wdata = (state_q == S_WRITE) ? word_q : '0;
  assign cpu_hold  = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: exact-cycle load, wait states, illegal counts,
// full-depth load, abort, asynchronous reset and start-while-busy.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  word_count = '0;
  logic        abort = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  logic [3:0]  last_we_addr = '0;
  logic [35:0] exp_q[$];

  inst_mem_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge, score any memory write.
  task automatic tick();
    logic [35:0] e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      n_we++;
      last_we_addr = mem_addr;
      if (exp_q.size() == 0) begin
        chk("we_unexpected", {35'd0, mem_we}, 36'd0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", {32'd0, mem_addr}, {32'd0, e[35:32]});
        chk("we_data", {4'd0, mem_wdata}, {4'd0, e[31:0]});
      end
    end
  endtask

  task automatic push_word(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_start(input logic [4:0] cnt);
    start = 1'b1;
    word_count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    int n;
    in_valid = 1'b0;
    repeat (gaps) tick();
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", {35'd0, in_ready}, 36'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", {35'd0, done}, 36'd1);
  endtask

  initial begin
    int we0;
    // reset state
    #2;
    chk("rst_busy", {35'd0, busy}, 36'd0);
    chk("rst_hold", {35'd0, cpu_hold}, 36'd0);
    chk("rst_ready", {35'd0, in_ready}, 36'd0);
    chk("rst_addr_data", {mem_addr, mem_wdata}, 36'd0);
    chk("rst_state", {34'd0, state_dbg}, 36'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: two words, in_valid held high, exact cycles
    push_word(4'd0, 32'h08000004);
    push_word(4'd1, 32'hAC040000);
    we0 = n_we;
    do_start(5'd2);
    chk("t1_recv_ready", {35'd0, in_ready}, 36'd1);
    chk("t1_recv_hold", {35'd0, cpu_hold}, 36'd1);
    in_valid = 1'b1;
    in_data = 8'h08; tick();
    in_data = 8'h00; tick();
    in_data = 8'h00; tick();
    in_data = 8'h04; tick();
    chk("t1_we0", {35'd0, mem_we}, 36'd1);
    chk("t1_w_ready", {35'd0, in_ready}, 36'd0);
    in_data = 8'hAC; tick();
    chk("t1_we_off", {35'd0, mem_we}, 36'd0);
    chk("t1_ready_back", {35'd0, in_ready}, 36'd1);
    tick();
    in_data = 8'h04; tick();
    in_data = 8'h00; tick();
    in_data = 8'h00; tick();
    chk("t1_we1", {35'd0, mem_we}, 36'd1);
    in_valid = 1'b0;
    tick();
    chk("t1_done", {35'd0, done}, 36'd1);
    chk("t1_done_hold", {35'd0, cpu_hold}, 36'd1);
    tick();
    chk("t1_done_pulse", {35'd0, done}, 36'd0);
    chk("t1_hold_off", {35'd0, cpu_hold}, 36'd0);
    chk("t1_nwrites", 36'(n_we - we0), 36'd2);

    // 2: same load with 3 wait cycles before every byte
    push_word(4'd0, 32'h08000004);
    push_word(4'd1, 32'hAC040000);
    we0 = n_we;
    do_start(5'd2);
    send_byte(8'h08, 3); send_byte(8'h00, 3); send_byte(8'h00, 3); send_byte(8'h04, 3);
    send_byte(8'hAC, 3); send_byte(8'h04, 3); send_byte(8'h00, 3); send_byte(8'h00, 3);
    wait_done();
    tick();
    chk("t2_hold_off", {35'd0, cpu_hold}, 36'd0);
    chk("t2_nwrites", 36'(n_we - we0), 36'd2);

    // 3: illegal counts
    do_start(5'd0);
    chk("t3_err0", {35'd0, err}, 36'd1);
    chk("t3_busy0", {34'd0, busy, cpu_hold}, 36'd0);
    tick();
    chk("t3_err0_pulse", {35'd0, err}, 36'd0);
    do_start(5'd17);
    chk("t3_err17", {35'd0, err}, 36'd1);
    chk("t3_busy17", {33'd0, busy, cpu_hold, mem_we}, 36'd0);
    tick();
    chk("t3_err17_pulse", {35'd0, err}, 36'd0);

    // 4: full depth, incrementing bytes
    we0 = n_we;
    for (int k = 0; k < 16; k++)
      push_word(4'(k), {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    do_start(5'd16);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
    wait_done();
    chk("t4_nwrites", 36'(n_we - we0), 36'd16);
    chk("t4_last_addr", {32'd0, last_we_addr}, 36'd15);
    chk("t4_queue_empty", 36'(exp_q.size()), 36'd0);
    tick();

    // 5: abort two bytes into word 1 (abort coincides with an offered byte)
    push_word(4'd0, 32'h11223344);
    we0 = n_we;
    do_start(5'd2);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("t5_idle", {34'd0, state_dbg}, 36'd0);
    chk("t5_no_hold", {34'd0, busy, cpu_hold}, 36'd0);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("t5_no_done", {35'd0, done}, 36'd0);
    chk("t5_nwrites", 36'(n_we - we0), 36'd1);
    push_word(4'd0, 32'h12345678);
    do_start(5'd1);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    wait_done();
    tick();

    // 6a: reset mid-word
    do_start(5'd1);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_outs", {31'd0, busy, cpu_hold, in_ready, done, err}, 36'd0);
    chk("t6_rst_state", {34'd0, state_dbg}, 36'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 6b: start during RECV is ignored
    push_word(4'd0, 32'hCAFEF00D);
    push_word(4'd1, 32'h0BADBEEF);
    do_start(5'd2);
    send_byte(8'hCA, 0); send_byte(8'hFE, 0);
    start = 1'b1;
    word_count = 5'd5;
    tick();
    start = 1'b0;
    chk("t6_no_err", {35'd0, err}, 36'd0);
    chk("t6_still_recv", {34'd0, state_dbg}, 36'd1);
    send_byte(8'hF0, 0); send_byte(8'h0D, 0);
    send_byte(8'h0B, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    wait_done();
    tick();
    chk("t6_queue_empty", 36'(exp_q.size()), 36'd0);
    chk("t6_idle_end", {34'd0, busy, cpu_hold}, 36'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart to the instruction memory: loads program words into its write port from a byte stream (boot/debug link) before the CPU runs.
- Assembles incoming bytes big-endian into 32-bit words and writes them at word addresses 0, 1, 2, … up to a requested count.
- Holds the CPU stalled (cpu_hold) for the whole load, then releases it.

Parameters:
- DEPTH, 16, number of 32-bit words in the instruction memory.
- ADDR_W, 4, word address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately).
- start  input  1  single-cycle load request; sampled only in IDLE.
- word_count  input  ADDR_W+1  words to load; legal range 1..DEPTH; sampled with start.
- abort  input  1  cancel the load in progress.
- in_data  input  8  stream byte; the first byte of each word is its MSB.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDR_W  word index being written.
- mem_wdata  output  32  word being written.
- cpu_hold  output  1  CPU stall/reset request while loading.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse: all requested words have been written.
- err  output  1  one-cycle pulse: start was rejected because word_count was illegal.

Behaviour:
- Reset (async assert): state=IDLE; word register, byte counter, address counter and stored count all clear to 0. All outputs are 0, and mem_addr and mem_wdata are also 0.
- States: IDLE, RECV, WRITE, DONE. Outputs are decoded from the registered state and registers.
- IDLE:
  - in_ready=0, cpu_hold=0, busy=0.
  - start with word_count 1..DEPTH: latch the count, clear addr and byte_cnt, go to RECV.
  - start with word_count 0 or >DEPTH: err=1 on the next cycle, stay in IDLE.
- RECV:
  - in_ready=1, cpu_hold=1.
  - A byte is accepted on a cycle with in_valid && in_ready: word <= {word[23:0], in_data}; byte_cnt increments (2-bit).
  - Acceptance of the 4th byte goes to WRITE.
  - in_valid low inserts wait cycles with no state change.
- WRITE (exactly 1 cycle):
  - in_ready=0; mem_we=1; mem_addr=addr; mem_wdata=word.
  - If addr == count-1, go to DONE. Otherwise addr increments, byte_cnt=0, go to RECV.
- DONE (1 cycle): done=1, cpu_hold still 1; next state IDLE, where cpu_hold=0.
- Latency: the 4th byte accepted in cycle N gives mem_we in cycle N+1. For the last word, done is in cycle N+2 and cpu_hold deasserts in cycle N+3.
- Throughput: at most one word per 5 cycles (4 RECV + 1 WRITE).
- abort:
  - In RECV: go to IDLE next cycle; the partial word is discarded with no write and no done.
  - In WRITE: the write in that cycle still occurs, then go to IDLE with no done.
  - In IDLE or DONE: ignored.
  - Simultaneous abort and byte acceptance in RECV: the byte is discarded and abort wins.
- start outside IDLE is ignored. No err pulse is produced and the load continues unchanged.
- Reset mid-load: outputs clear at once; words already written remain in memory; the next start restarts from address 0.
- Address never wraps: the maximum is DEPTH-1 when word_count==DEPTH.
- Bytes offered while in_ready=0 are not consumed; the source must hold them.

Test Plan:
- start, word_count=2, bytes 08 00 00 04 AC 04 00 00 with in_valid held high -> mem_we at addr 0 with 0x08000004, then at addr 1 with 0xAC040000. done occurs 1 cycle after the second write and cpu_hold falls 1 cycle later. Cycle counts must be exact.
- Same load with in_valid deasserted for 3 cycles between bytes -> identical writes, only delayed; no byte lost or duplicated.
- start with word_count=0, then with word_count=17 -> err pulses once each; busy, cpu_hold and mem_we stay 0.
- word_count=16, 64 bytes of an incrementing pattern -> 16 writes at addr 0..15, the last at 15, no wrap, then done.
- abort after 2 bytes of word 1 -> no write for word 1, no done, IDLE next cycle. A following start loads correctly from addr 0.
- Drive reset to 0 mid-word, and separately pulse start while in RECV -> reset: all outputs 0 immediately. start during RECV: ignored and the load completes normally.
